// File: rtl/cc_miss_req_ctrl_if.sv
// Miss-request, AXI AR/R-monitor and miss-address FIFO push signals of the line-fill sequencer.
// master = sequencer side, slave = cache pipeline / memory / FIFO side.
interface cc_miss_req_ctrl_if #(parameter int CNT_W = 2);
  logic             miss_req_valid_i;
  logic [31:0]      miss_req_addr_i;
  logic             miss_req_ready_o;
  logic             mem_arvalid_o;
  logic             mem_arready_i;
  logic [31:0]      mem_araddr_o;
  logic [3:0]       mem_arlen_o;
  logic [2:0]       mem_arsize_o;
  logic [1:0]       mem_arburst_o;
  logic             mem_rvalid_i;
  logic             mem_rready_i;
  logic             mem_rlast_i;
  logic             miss_addr_fifo_full_i;
  logic             miss_addr_fifo_wren_o;
  logic [31:0]      miss_addr_fifo_wdata_o;
  logic [CNT_W-1:0] outstanding_o;
  logic             busy_o;
  logic             protocol_err_o;

  modport master (
    input  miss_req_valid_i, miss_req_addr_i, mem_arready_i,
           mem_rvalid_i, mem_rready_i, mem_rlast_i, miss_addr_fifo_full_i,
    output miss_req_ready_o, mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o,
           mem_arburst_o, miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o,
           outstanding_o, busy_o, protocol_err_o
  );

  modport slave (
    output miss_req_valid_i, miss_req_addr_i, mem_arready_i,
           mem_rvalid_i, mem_rready_i, mem_rlast_i, miss_addr_fifo_full_i,
    input  miss_req_ready_o, mem_arvalid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o,
           mem_arburst_o, miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o,
           outstanding_o, busy_o, protocol_err_o
  );
endinterface

// File: rtl/cc_miss_req_ctrl.sv
// Line-fill miss sequencer: one 8x64b WRAP AXI read per miss, outstanding-fill throttle.
// Optional macro CC_SAME_LINE_STALL_EN holds off a miss to the line most recently issued.
module cc_miss_req_ctrl #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  cc_miss_req_ctrl_if.master bus
);

  typedef enum logic {IDLE, AR_REQ} state_t;

  state_t           state;
  logic [31:0]      miss_addr;
  logic [31:0]      araddr;
  logic             arvalid;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] cnt_nxt;
  logic             perr;
  logic             ar_hs;
  logic             r_done;
  logic             stall;
  logic             can_accept;

  assign ar_hs  = (state == AR_REQ) && bus.mem_arready_i;
  assign r_done = bus.mem_rvalid_i && bus.mem_rready_i && bus.mem_rlast_i;

  // Simultaneous issue and completion cancel; an unmatched completion at zero saturates.
  always_comb begin
    cnt_nxt = outstanding;
    if (ar_hs && !r_done)
      cnt_nxt = outstanding + CNT_W'(1);
    else if (r_done && !ar_hs && (outstanding != '0))
      cnt_nxt = outstanding - CNT_W'(1);
  end

`ifdef CC_SAME_LINE_STALL_EN
  logic [25:0] lastline;
  logic        line_vld;
  assign stall = line_vld && (bus.miss_req_addr_i[31:6] == lastline);
`else
  assign stall = 1'b0;
`endif

  assign can_accept = (state == IDLE) && (outstanding < CNT_W'(MAX_OUTSTANDING)) &&
                      !bus.miss_addr_fifo_full_i && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      miss_addr   <= '0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      outstanding <= '0;
      perr        <= 1'b0;
`ifdef CC_SAME_LINE_STALL_EN
      lastline    <= '0;
      line_vld    <= 1'b0;
`endif
    end else begin
      outstanding <= cnt_nxt;
      if (r_done && !ar_hs && (outstanding == '0))
        perr <= 1'b1;
      case (state)
        IDLE: if (bus.miss_req_valid_i && can_accept) begin
          miss_addr <= bus.miss_req_addr_i;
          araddr    <= {bus.miss_req_addr_i[31:3], 3'b000};
          arvalid   <= 1'b1;
          state     <= AR_REQ;
        end
        AR_REQ: if (bus.mem_arready_i) begin
          arvalid <= 1'b0;
          state   <= IDLE;
          if (bus.miss_addr_fifo_full_i)
            perr <= 1'b1;
        end
      endcase
`ifdef CC_SAME_LINE_STALL_EN
      if (ar_hs) begin
        lastline <= miss_addr[31:6];
        line_vld <= 1'b1;
      end else if (cnt_nxt == '0) begin
        line_vld <= 1'b0;
      end
`endif
    end
  end

  assign bus.miss_req_ready_o       = can_accept;
  assign bus.mem_arvalid_o          = arvalid;
  assign bus.mem_araddr_o           = araddr;
  assign bus.mem_arlen_o            = 4'd7;
  assign bus.mem_arsize_o           = 3'd3;
  assign bus.mem_arburst_o          = 2'b10;
  // Full address goes to the fill unit; it derives the wrap start from bits [5:3].
  assign bus.miss_addr_fifo_wren_o  = ar_hs;
  assign bus.miss_addr_fifo_wdata_o = miss_addr;
  assign bus.outstanding_o          = outstanding;
  assign bus.busy_o                 = (state != IDLE) || (outstanding != '0);
  assign bus.protocol_err_o         = perr;

endmodule

// File: tb/tb_cc_miss_req_ctrl.sv
// Randomized + directed bench; a transaction-level model predicts ready/AR/counter/error,
// accepted misses queue expected FIFO pushes that a negedge monitor pops and compares.
module tb_cc_miss_req_ctrl;
  localparam int MAXO  = 2;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cc_miss_req_ctrl_if #(.CNT_W(CNT_W)) bus ();
  cc_miss_req_ctrl #(.MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int fails   = 0;

  // reference model: fills in flight, one pending AR, sticky error, last issued line
  int          m_cnt;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  bit          m_err;
  bit          m_lvld;
  logic [25:0] m_lline;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit          exp_rdy, acc, ar, rd, stl;
    int          nxt;
    logic [31:0] e;
    if (!rst_n) begin
      m_cnt = 0; m_pend = 0; m_pend_addr = '0; m_err = 0; m_lvld = 0; m_lline = '0;
      exp_q.delete();
    end else begin
      stl = 0;
`ifdef CC_SAME_LINE_STALL_EN
      stl = m_lvld && (bus.miss_req_addr_i[31:6] == m_lline);
`endif
      exp_rdy = !m_pend && (m_cnt < MAXO) && !bus.miss_addr_fifo_full_i && !stl;
      chk("ready", 32'(bus.miss_req_ready_o), 32'(exp_rdy));
      chk("arvalid", 32'(bus.mem_arvalid_o), 32'(m_pend));
      if (m_pend) chk("araddr", bus.mem_araddr_o, {m_pend_addr[31:3], 3'b000});
      chk("arlen", 32'(bus.mem_arlen_o), 32'd7);
      chk("arsize", 32'(bus.mem_arsize_o), 32'd3);
      chk("arburst", 32'(bus.mem_arburst_o), 32'd2);
      chk("wren", 32'(bus.miss_addr_fifo_wren_o), 32'(m_pend && bus.mem_arready_i));
      if (bus.miss_addr_fifo_wren_o) begin
        if (exp_q.size() == 0) begin
          vectors++; fails++;
          $display("FAIL wdata: push 0x%0h with no expected entry", bus.miss_addr_fifo_wdata_o);
        end else begin
          e = exp_q.pop_front();
          chk("wdata", bus.miss_addr_fifo_wdata_o, e);
        end
      end
      chk("outstanding", 32'(bus.outstanding_o), 32'(m_cnt));
      chk("busy", 32'(bus.busy_o), 32'(m_pend || (m_cnt != 0)));
      chk("protocol_err", 32'(bus.protocol_err_o), 32'(m_err));

      acc = bus.miss_req_valid_i && exp_rdy;
      ar  = m_pend && bus.mem_arready_i;
      rd  = bus.mem_rvalid_i && bus.mem_rready_i && bus.mem_rlast_i;
      nxt = m_cnt + (ar ? 1 : 0) - (rd ? 1 : 0);
      if (nxt < 0) begin nxt = 0; m_err = 1; end
      if (ar && bus.miss_addr_fifo_full_i) m_err = 1;
      if (ar) begin m_lvld = 1; m_lline = m_pend_addr[31:6]; end
      else if (nxt == 0) m_lvld = 0;
      m_cnt = nxt;
      if (ar) m_pend = 0;
      if (acc) begin
        m_pend = 1; m_pend_addr = bus.miss_req_addr_i;
        exp_q.push_back(bus.miss_req_addr_i);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input bit arr,
                       input bit rv, input bit rl, input bit full);
    bus.miss_req_valid_i      = v;
    bus.miss_req_addr_i       = a;
    bus.mem_arready_i         = arr;
    bus.mem_rvalid_i          = rv;
    bus.mem_rready_i          = rv;
    bus.mem_rlast_i           = rl;
    bus.miss_addr_fifo_full_i = full;
  endtask

  task automatic do_reset();
    drive(0, '0, 0, 0, 0, 0);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  initial begin
    drive(0, '0, 0, 0, 0, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // single miss, arready after 3 cycles, then an 8-beat fill
    drive(1, 32'h0000_1238, 0, 0, 0, 0); cyc(1);
    drive(0, '0, 0, 0, 0, 0); cyc(3);
    drive(0, '0, 1, 0, 0, 0); cyc(1);
    for (int i = 0; i < 8; i++) begin drive(0, '0, 0, 1, i == 7, 0); cyc(1); end
    drive(0, '0, 0, 0, 0, 0); cyc(2);

    // back-to-back misses, arready always high, no R until throttled
    drive(1, 32'h0000_4000, 1, 0, 0, 0); cyc(2);
    drive(1, 32'h0000_5008, 1, 0, 0, 0); cyc(2);
    drive(1, 32'h0000_6010, 1, 0, 0, 0); cyc(3);
    drive(1, 32'h0000_6010, 1, 1, 1, 0); cyc(1);
    drive(0, '0, 1, 0, 0, 0); cyc(3);
    do_reset(); cyc(1);

    // issue and completion in the same cycle with one fill in flight
    drive(1, 32'h0000_7000, 1, 0, 0, 0); cyc(1);
    drive(0, '0, 1, 0, 0, 0); cyc(1);
    drive(1, 32'h0000_8000, 0, 0, 0, 0); cyc(1);
    drive(0, '0, 1, 1, 1, 0); cyc(1);
    drive(0, '0, 0, 0, 0, 0); cyc(2);
    do_reset(); cyc(1);

    // underflow: sticky error until reset
    drive(0, '0, 0, 1, 1, 0); cyc(1);
    drive(0, '0, 0, 0, 0, 0); cyc(4);
    do_reset(); cyc(2);

    // FIFO full blocks acceptance
    drive(1, 32'h0000_9100, 0, 0, 0, 1); cyc(3);
    drive(1, 32'h0000_9100, 0, 0, 0, 0); cyc(1);
    drive(0, '0, 1, 0, 0, 0); cyc(1);
    drive(0, '0, 0, 0, 0, 0); cyc(1);
    do_reset(); cyc(1);

    // same-line miss while its fill is in flight, then a different line
    drive(1, 32'h0000_2040, 1, 0, 0, 0); cyc(1);
    drive(0, '0, 1, 0, 0, 0); cyc(1);
    drive(1, 32'h0000_2078, 0, 0, 0, 0); cyc(3);
    drive(1, 32'h0000_2078, 0, 1, 1, 0); cyc(1);
    drive(1, 32'h0000_2078, 1, 0, 0, 0); cyc(2);
    drive(1, 32'h0000_3040, 1, 0, 0, 0); cyc(1);
    drive(0, '0, 1, 0, 0, 0); cyc(2);
    do_reset(); cyc(1);

    // randomized traffic over a few lines so same-line and throttle cases recur
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      drive($urandom_range(0, 1) == 1,
            32'h0000_2000 + 32'($urandom_range(0, 3) << 6) + 32'($urandom_range(0, 63)),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0);
      cyc(1);
    end
    drive(0, '0, 0, 0, 0, 0);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
